// File: rtl/banked_imem_loader.sv
// Byte-banked instruction memory with a direct word-write port and a UART byte-stream loader.
// Define IMEM_SYNC_READ_EN for a registered read port; otherwise reads are combinational.

module imem_bank #(
    parameter int ROWS = 256,
    parameter int RW   = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [RW-1:0] raddr,
    output logic [7:0]    rdata
);
    // Zero image at time zero; reset never touches the array.
    logic [7:0] mem [ROWS] = '{default: 8'h00};

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

module banked_imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    w_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    ld_start,
    input  logic [ADDR_WIDTH-1:0]   ld_base,
    input  logic [7:0]              ld_byte,
    input  logic                    ld_valid,
    input  logic                    ld_last,
    output logic                    ld_ready,
    output logic                    ld_busy,
    output logic                    ld_done,
    output logic                    ld_wrap
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int LW   = $clog2(NB);
    localparam int ROWS = MEM_DEPTH / NB;
    localparam int RW   = ADDR_WIDTH - LW;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;
    state_t state, state_nx;

    logic [LW-1:0]        k;
    logic [NB-1:0]        mask;
    logic [NB-1:0][7:0]   asm_word;
    logic                 last_q;
    logic [RW-1:0]        row;
    logic                 hs, commit_go;

    logic [NB-1:0]        bank_we;
    logic [RW-1:0]        bank_waddr;
    logic [NB-1:0][7:0]   bank_wdata;
    logic [NB-1:0][7:0]   rd_word;
    logic                 unused_bits;

    assign unused_bits = ^{rd_addr[LW-1:0], wr_addr[LW-1:0], ld_base[LW-1:0]};

    assign hs        = (state == S_LOAD) && ld_valid && ld_ready;
    // A restart discards the pending word, and the direct write port always wins.
    assign commit_go = (state == S_COMMIT) && !w_en && !ld_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ld_ready = 1'b0;
        ld_busy  = 1'b0;
        case (state)
            S_IDLE: begin
                if (ld_start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                ld_ready = !w_en;
                ld_busy  = 1'b1;
                if (ld_start)
                    state_nx = S_LOAD;
                else if (hs && (k == LW'(NB - 1) || ld_last))
                    state_nx = S_COMMIT;
            end
            S_COMMIT: begin
                ld_busy = 1'b1;
                if (ld_start)
                    state_nx = S_LOAD;
                else if (!w_en)
                    state_nx = last_q ? S_IDLE : S_LOAD;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= '0;
            mask     <= '0;
            asm_word <= '0;
            last_q   <= 1'b0;
            row      <= '0;
            ld_wrap  <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            if (ld_start) begin
                row     <= ld_base[ADDR_WIDTH-1:LW];
                k       <= '0;
                mask    <= '0;
                last_q  <= 1'b0;
                ld_wrap <= 1'b0;
            end else if (hs) begin
                asm_word[k] <= ld_byte;
                mask[k]     <= 1'b1;
                k           <= k + LW'(1);
                last_q      <= ld_last;
            end else if (commit_go) begin
                row     <= row + RW'(1);
                k       <= '0;
                mask    <= '0;
                ld_done <= last_q;
                if (row == '1) ld_wrap <= 1'b1;
            end
        end
    end

    assign bank_waddr = w_en ? wr_addr[ADDR_WIDTH-1:LW] : row;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign bank_we[i]    = w_en ? wr_be[i] : (commit_go && mask[i]);
        assign bank_wdata[i] = w_en ? data_in[8*i +: 8] : asm_word[i];

        imem_bank #(.ROWS(ROWS), .RW(RW)) u_bank (
            .clk   (clk),
            .we    (bank_we[i]),
            .waddr (bank_waddr),
            .wdata (bank_wdata[i]),
            .raddr (rd_addr[ADDR_WIDTH-1:LW]),
            .rdata (rd_word[i])
        );
    end

`ifdef IMEM_SYNC_READ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_word;
        end
    end
`else
    assign rd_data  = rd_word;
    assign rd_valid = rd_en;
`endif
endmodule

// File: tb/tb_banked_imem_loader.sv
// Directed bench for banked_imem_loader: direct writes, stream loads, wrap, contention, abort, reset.

module tb_banked_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        w_en;
    logic [9:0]  wr_addr;
    logic [31:0] data_in;
    logic [3:0]  wr_be;
    logic        ld_start;
    logic [9:0]  ld_base;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_wrap;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] rv;

    banked_imem_loader dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .w_en(w_en), .wr_addr(wr_addr), .data_in(data_in), .wr_be(wr_be),
        .ld_start(ld_start), .ld_base(ld_base), .ld_byte(ld_byte),
        .ld_valid(ld_valid), .ld_last(ld_last), .ld_ready(ld_ready),
        .ld_busy(ld_busy), .ld_done(ld_done), .ld_wrap(ld_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        w_en = 1'b1; wr_addr = a; data_in = d; wr_be = be;
        tick();
        w_en = 1'b0; wr_be = 4'h0;
    endtask

    task automatic rd(input logic [9:0] a, output logic [31:0] d);
        rd_en = 1'b1; rd_addr = a;
`ifdef IMEM_SYNC_READ_EN
        tick();
`else
        #1;
`endif
        d = rd_data;
        rd_en = 1'b0;
    endtask

    task automatic start(input logic [9:0] b);
        ld_start = 1'b1; ld_base = b;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        ld_valid = 1'b1; ld_byte = b; ld_last = last;
        while (!ld_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("ready_timeout", {31'd0, ld_ready}, 32'd1);
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rd_en = 0; rd_addr = 0; w_en = 0; wr_addr = 0; data_in = 0; wr_be = 0;
        ld_start = 0; ld_base = 0; ld_byte = 0; ld_valid = 0; ld_last = 0;
        tick(); tick();
        chk("rst_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_busy",  {31'd0, ld_busy},  32'd0);
        chk("rst_done",  {31'd0, ld_done},  32'd0);
        chk("rst_wrap",  {31'd0, ld_wrap},  32'd0);
        chk("rst_rvalid", {31'd0, rd_valid}, 32'd0);
`ifdef IMEM_SYNC_READ_EN
        chk("rst_rdata", rd_data, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Zero image and direct byte-enabled writes
        rd(10'h014, rv); chk("zero_init", rv, 32'h0);
        wr(10'h010, 32'hDEADBEEF, 4'hF);
        wr(10'h010, 32'h00001234, 4'h3);
        rd(10'h010, rv); chk("direct_be", rv, 32'hDEAD1234);

        // Read latency and read-during-write returns old data
        w_en = 1'b1; wr_addr = 10'h010; data_in = 32'hCAFEF00D; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 10'h010;
        #1;
`ifdef IMEM_SYNC_READ_EN
        chk("lat_pre", {31'd0, rd_valid}, 32'd0);
        tick();
        w_en = 1'b0;
        chk("lat_valid", {31'd0, rd_valid}, 32'd1);
        chk("rdw_old", rd_data, 32'hDEAD1234);
`else
        chk("lat_valid", {31'd0, rd_valid}, 32'd1);
        chk("rdw_old", rd_data, 32'hDEAD1234);
        tick();
        w_en = 1'b0;
`endif
        rd_en = 1'b0;
        rd(10'h010, rv); chk("rdw_new", rv, 32'hCAFEF00D);

        // Full two-word stream
        start(10'h000);
        chk("ld_busy", {31'd0, ld_busy}, 32'd1);
        chk("ld_ready", {31'd0, ld_ready}, 32'd1);
        send(8'h13, 0); send(8'h00, 0); send(8'h50, 0); send(8'h00, 0);
        send(8'h93, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 1);
        chk("commit_ready", {31'd0, ld_ready}, 32'd0);
        chk("commit_busy", {31'd0, ld_busy}, 32'd1);
        tick();
        chk("done_pulse", {31'd0, ld_done}, 32'd1);
        chk("idle_busy", {31'd0, ld_busy}, 32'd0);
        tick();
        chk("done_clear", {31'd0, ld_done}, 32'd0);
        rd(10'h000, rv); chk("stream_w0", rv, 32'h00500013);
        rd(10'h004, rv); chk("stream_w1", rv, 32'h00100093);

        // Partial final word keeps untouched lanes
        wr(10'h020, 32'hFFFFFFFF, 4'hF);
        start(10'h020);
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 1);
        tick(); tick();
        rd(10'h020, rv); chk("partial", rv, 32'hFFCCBBAA);

        // Wrap past top of memory
        start(10'h3FC);
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 1);
        tick(); tick();
        chk("wrap_set", {31'd0, ld_wrap}, 32'd1);
        rd(10'h3FC, rv); chk("wrap_top", rv, 32'h04030201);
        rd(10'h000, rv); chk("wrap_row0", rv, 32'h08070605);
        tick();
        chk("wrap_sticky", {31'd0, ld_wrap}, 32'd1);

        // Direct write stalls a pending commit
        start(10'h100);
        chk("wrap_clear", {31'd0, ld_wrap}, 32'd0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        w_en = 1'b1; wr_addr = 10'h200; data_in = 32'h55667788; wr_be = 4'hF;
        tick(); tick();
        chk("stall_busy", {31'd0, ld_busy}, 32'd1);
        chk("stall_ready", {31'd0, ld_ready}, 32'd0);
        w_en = 1'b0; wr_be = 4'h0;
        tick();
        chk("load_ready", {31'd0, ld_ready}, 32'd1);
        w_en = 1'b1;
        #1;
        chk("load_ready_wen", {31'd0, ld_ready}, 32'd0);
        w_en = 1'b0;
        #1;
        rd(10'h100, rv); chk("contend_ld", rv, 32'h44332211);
        rd(10'h200, rv); chk("contend_wr", rv, 32'h55667788);

        // Restart discards partial word
        send(8'h99, 0); send(8'h98, 0);
        start(10'h180);
        send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 1);
        tick(); tick();
        rd(10'h104, rv); chk("abort_nowrite", rv, 32'h0);
        rd(10'h180, rv); chk("abort_restart", rv, 32'hA4A3A2A1);

        // Stream bytes offered in IDLE are not consumed
        ld_valid = 1'b1; ld_byte = 8'hEE;
        tick();
        chk("idle_ready", {31'd0, ld_ready}, 32'd0);
        tick();
        ld_valid = 1'b0;
        start(10'h300);
        send(8'h01, 1);
        tick(); tick();
        rd(10'h300, rv); chk("idle_ignore", rv, 32'h00000001);

        // Reset mid-load
        start(10'h140);
        send(8'h5A, 0); send(8'h5B, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy",  {31'd0, ld_busy},  32'd0);
        chk("mrst_ready", {31'd0, ld_ready}, 32'd0);
        chk("mrst_done",  {31'd0, ld_done},  32'd0);
        chk("mrst_wrap",  {31'd0, ld_wrap},  32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("mrst_idle", {31'd0, ld_busy}, 32'd0);
        rd(10'h140, rv); chk("mrst_lost", rv, 32'h0);
        rd(10'h010, rv); chk("mrst_keep", rv, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/banked_imem_loader.md
BANKED_IMEM_LOADER -- requirements
Module: banked_imem_loader

Interface
REQ-001 The block SHALL have these parameters: DATA_WIDTH, default 32, instruction width in bits (a multiple of 8, at least 16); MEM_DEPTH, default 1024, memory size in bytes (a power of two, a multiple of DATA_WIDTH/8); ADDR_WIDTH, default $clog2(MEM_DEPTH), byte-address width.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read byte address (PC); the low $clog2(DATA_WIDTH/8) bits are ignored.
- rd_data  out  DATA_WIDTH  instruction read.
- rd_valid  out  1  rd_data is valid.
- w_en  in  1  direct word write.
- wr_addr  in  ADDR_WIDTH  direct write byte address; the low bits are ignored.
- data_in  in  DATA_WIDTH  direct write data.
- wr_be  in  DATA_WIDTH/8  direct write byte enables; bit i gates byte lane i.
- ld_start  in  1  starts a byte-stream load at ld_base.
- ld_base  in  ADDR_WIDTH  load start byte address; it is word aligned and the low bits are ignored.
- ld_byte  in  8  stream byte from the UART RX FIFO.
- ld_valid  in  1  ld_byte is valid.
- ld_last  in  1  final byte of the stream; qualified by ld_valid.
- ld_ready  out  1  loader accepts ld_byte this cycle.
- ld_busy  out  1  a load is in progress.
- ld_done  out  1  one-cycle pulse when the last word is committed.
- ld_wrap  out  1  sticky flag: the load address wrapped past the top of memory.

Function
REQ-003 Storage SHALL be DATA_WIDTH/8 byte-wide banks of MEM_DEPTH/(DATA_WIDTH/8) entries; lane 0 holds the LSB.
REQ-004 A direct write SHALL update only the lanes with wr_be set, at the row given by the upper wr_addr bits, on the clk edge where w_en=1.
REQ-005 The loader FSM SHALL have three states:
- IDLE: ld_ready=0, ld_busy=0; moves to LOAD on ld_start.
- LOAD: ld_ready=!w_en, ld_busy=1.
- COMMIT: ld_ready=0, ld_busy=1; lasts one cycle.
REQ-006 In LOAD, a handshake (ld_valid & ld_ready) SHALL place ld_byte into lane k of the assembly register, with k counting from 0 (little-endian).
REQ-007 When lane DATA_WIDTH/8-1 fills, or ld_last is accepted, the FSM SHALL enter COMMIT.
REQ-008 In COMMIT, the FSM SHALL write the assembled word with byte enables for the received lanes only, advance the row, and clear k.
REQ-009 After COMMIT, the FSM SHALL go to IDLE with ld_done=1 for one cycle if the last byte was committed; otherwise it SHALL return to LOAD.
REQ-010 A COMMIT coinciding with w_en SHALL stall in COMMIT until w_en=0; the direct write wins.
REQ-011 The row counter SHALL wrap from the top row to row 0 and set ld_wrap; ld_wrap clears on the next ld_start.
REQ-012 ld_start asserted in LOAD or COMMIT SHALL discard the partial word without writing it and restart at ld_base with k=0.
REQ-013 ld_valid asserted in IDLE SHALL be ignored and no byte SHALL be consumed.
REQ-014 A read of a row written in the same cycle SHALL return the old data.
REQ-015 Memory SHALL initialise to all zeros at time zero.

Reset
REQ-016 While rst_n=0, the block SHALL hold: FSM=IDLE, k=0, row=0, ld_ready=0, ld_busy=0, ld_done=0, ld_wrap=0, rd_valid=0, and rd_data=0 (registered mode).
REQ-017 Reset SHALL NOT clear memory contents; a partial word in flight at reset SHALL be lost.

Configuration
REQ-018 With IMEM_SYNC_READ_EN defined, reads SHALL be registered: rd_data and rd_valid update one cycle after rd_en, and rd_data holds its value when rd_en=0.
REQ-019 With IMEM_SYNC_READ_EN undefined, reads SHALL be combinational: rd_data follows rd_addr, and rd_valid=rd_en.

Verification
REQ-020 Direct write then read: w_en with addr 0x010, data 0xDEADBEEF, be 0xF, then be 0x3 with 0x00001234; read 0x010 -> 0xDEAD1234.
REQ-021 Stream load: ld_start with base 0x000, then bytes 13,00,50,00,93,00,10,00 (last on the 8th) -> word 0=0x00500013, word 1=0x00100093, one ld_done pulse, ld_busy low after.
REQ-022 Partial last word: base 0x020, bytes AA,BB,CC with ld_last on CC, prior contents 0xFFFFFFFF -> word 0x020 reads 0xFFCCBBAA.
REQ-023 Wrap: base 0x3FC, 8 bytes -> words at 0x3FC and 0x000 written, ld_wrap=1 until the next ld_start.
REQ-024 Contention and abort: w_en held during COMMIT -> ld_ready=0, the commit is delayed, both writes land. ld_start after 2 bytes -> no write, restart at the new base. rst_n low mid-load -> IDLE, all flags 0, memory unchanged.
REQ-025 Read latency: run REQ-020 with and without IMEM_SYNC_READ_EN -> rd_valid arrives 1 cycle after rd_en, or in the same cycle, respectively.
